pu_riscv_dbg_unit: RTL and testbench
====================================

Name: pu_riscv_dbg_unit

Overview:
- CPU-side debug unit: the slave that consumes the debug-controller bus (stall/strobe/we/addr/data) and answers with read data, ack and breakpoint-hit.
- Holds the control, hit-cause and hardware-breakpoint registers and the stopped-PC register, and gives GPR access through a register-file side port.
- Sits between the external debug controller and the integer pipeline; stalls the pipeline on a breakpoint, a single step or an ebreak.

Parameters:
- XLEN, 64, data width of the debug bus and GPRs
- PLEN, 64, address width of the debug bus and PCs
- NBP, 2, number of hardware PC breakpoints (1..8)

Ports:
- rstn  in  1  asynchronous active-low reset
- clk  in  1  single clock, rising edge
- dbg_stall_i  in  1  stall request from debug controller
- dbg_strb_i  in  1  bus strobe, held until ack sampled
- dbg_we_i  in  1  1 = write, 0 = read
- dbg_addr_i  in  PLEN  register address; only [15:0] decoded
- dbg_dati_i  in  XLEN  write data
- dbg_dato_o  out  XLEN  read data, valid while dbg_ack_o=1
- dbg_ack_o  out  1  one-cycle access acknowledge
- dbg_bp_o  out  1  one-cycle breakpoint/step/ebreak hit pulse
- pipe_valid_i  in  1  instruction at pipe_pc_i retires this cycle
- pipe_pc_i  in  PLEN  PC of the instruction in execute
- pipe_npc_i  in  PLEN  PC of the next instruction
- pipe_ebreak_i  in  1  instruction in execute is ebreak
- du_stall_o  out  1  pipeline stall
- du_rf_re_o  out  1  GPR read strobe
- du_rf_we_o  out  1  GPR write strobe
- du_rf_addr_o  out  5  GPR index
- du_rf_dat_o  out  XLEN  GPR write data
- rf_dat_i  in  XLEN  GPR read data, one cycle after du_rf_re_o

Behaviour:
- Reset values: all outputs 0. CTRL, HIT, BPCTRL, BPADR and NPC cleared. FSM in IDLE.
- Address map, on dbg_addr_i[15:0]:
  - 0x0000 CTRL: bit0 single_step, bit1 ebreak_en.
  - 0x0001 HIT, write-1-to-clear: bit0 step, bit1 ebreak, bit(4+n) BP n.
  - 0x0010+2n BPCTRL n: bit0 enable.
  - 0x0011+2n BPADR n.
  - 0x0100 NPC, read-only.
  - 0x1000..0x101F GPR x0..x31.
  - Unmapped addresses: read 0, write ignored, still acked.
- Bus FSM states: IDLE, RFRD, ACK, RELEASE.
  - IDLE, strb=1: go to ACK next cycle, except a GPR read while dbg_stall_i=1, which goes to RFRD.
  - RFRD: du_rf_re_o=1 for one cycle, then ACK; dbg_dato_o takes rf_dat_i.
  - ACK: dbg_ack_o=1 for exactly one cycle, then RELEASE.
  - RELEASE: return to IDLE once strb=0. No second access can complete on a strobe still held high.
  - Write latency: ack 1 cycle after strb is sampled. GPR read latency: 2 cycles.
- GPR write with dbg_stall_i=1: du_rf_we_o pulses one cycle in the ACK cycle.
  - Writes to x0 are dropped (no du_rf_we_o).
  - GPR access with dbg_stall_i=0: read returns 0, write dropped, still acked.
- Register writes take effect at the ack edge. Read data is stable throughout the ack cycle.
- Breakpoint n matches when BPCTRL n.enable=1, pipe_valid_i=1, du_stall_o=0 and pipe_pc_i==BPADR n.
  - Instruction is stopped before it executes; NPC <= pipe_pc_i.
- ebreak with ebreak_en=1 and pipe_valid_i=1: set HIT.bit1; NPC <= pipe_pc_i.
- Single step: when single_step=1 and dbg_stall_i falls, exactly one pipe_valid_i retirement is allowed.
  - On that retirement: set HIT.bit0; NPC <= pipe_npc_i.
- Any hit:
  - Sets its HIT bit(s) and pulses dbg_bp_o for one cycle.
  - Asserts an internal bp_hold, which clears when dbg_stall_i is sampled 1.
  - du_stall_o = dbg_stall_i | bp_hold | (hit-detect this cycle, combinational).
- Simultaneous events:
  - Several hits in the same cycle set all matching bits, give one dbg_bp_o pulse, and BP NPC takes priority.
  - A HIT write-1-to-clear in the same cycle as a new hit on the same bit leaves the bit set.
- Reset mid-access: ack and strobes drop immediately; no register update.

Test Plan:
- Write CTRL=0x3, then read CTRL → each ack 1 cycle after strb; read returns 0x3; ack pulse exactly 1 cycle wide.
- Stalled GPR: write x5=0xDEAD_BEEF → du_rf_we_o pulses with addr 5; read x5 (rf_dat_i=0xDEAD_BEEF) → re pulse, ack 2 cycles after strb, data 0xDEAD_BEEF; write x0 → no we pulse, ack given.
- BP0: BPADR0=0x200, enable=1, unstall, drive pipe_pc_i=0x200 with pipe_valid_i=1 → dbg_bp_o pulse, du_stall_o=1 same cycle, HIT=0x10, NPC=0x200.
- Single step: single_step=1, stall falls, two retirements with npc 0x104 then 0x108 → exactly one retire, HIT=0x1, NPC=0x104; write HIT=0x1 → HIT reads 0.
- Edge cases:
  - Unmapped address 0x0777 read → 0 with ack.
  - GPR read while unstalled → 0.
  - strb held high 5 cycles after ack → no second ack.
- Reset asserted during RFRD → ack never asserted, outputs 0; first access after reset completes normally.

Source files
------------

// File: rtl/pu_riscv_dbg_unit.sv
// CPU-side debug unit: debug-bus slave holding control, hit-cause, breakpoint and
// stopped-PC registers, with GPR access through the register-file side port.
module pu_riscv_dbg_unit #(
  parameter int XLEN = 64,
  parameter int PLEN = 64,
  parameter int NBP  = 2
) (
  input  logic            rstn,
  input  logic            clk,
  input  logic            dbg_stall_i,
  input  logic            dbg_strb_i,
  input  logic            dbg_we_i,
  input  logic [PLEN-1:0] dbg_addr_i,
  input  logic [XLEN-1:0] dbg_dati_i,
  output logic [XLEN-1:0] dbg_dato_o,
  output logic            dbg_ack_o,
  output logic            dbg_bp_o,
  input  logic            pipe_valid_i,
  input  logic [PLEN-1:0] pipe_pc_i,
  input  logic [PLEN-1:0] pipe_npc_i,
  input  logic            pipe_ebreak_i,
  output logic            du_stall_o,
  output logic            du_rf_re_o,
  output logic            du_rf_we_o,
  output logic [4:0]      du_rf_addr_o,
  output logic [XLEN-1:0] du_rf_dat_o,
  input  logic [XLEN-1:0] rf_dat_i
);

  localparam logic [15:0] ADR_CTRL = 16'h0000;
  localparam logic [15:0] ADR_HIT  = 16'h0001;
  localparam logic [15:0] ADR_BP   = 16'h0010;
  localparam logic [15:0] ADR_NPC  = 16'h0100;

  typedef enum logic [1:0] {IDLE, RFRD, ACK, RELEASE} state_t;
  state_t state;

  logic [1:0]      ctrl;
  logic            hit_step, hit_ebrk;
  logic [NBP-1:0]  hit_bp, bp_en, bp_match;
  logic [PLEN-1:0] bp_adr [NBP];
  logic [PLEN-1:0] npc;
  logic            bp_hold, stall_q, step_arm;

  logic [15:0]     adr;
  logic            unused_addr;
  logic            is_gpr, wr, wr_hit;
  logic            stall_base, run, ebrk_hit, step_hit, any_hit;
  logic [XLEN-1:0] rd_dat;

  assign adr         = dbg_addr_i[15:0];
  assign unused_addr = ^dbg_addr_i[PLEN-1:16];
  assign is_gpr      = (adr[15:5] == 11'h080);
  assign wr          = (state == IDLE) & dbg_strb_i & dbg_we_i;
  assign wr_hit      = wr & (adr == ADR_HIT);

  // Hits are only detected while the pipeline is free to run, so a held
  // instruction cannot re-trigger while the controller takes over.
  assign stall_base = dbg_stall_i | bp_hold;
  assign run        = pipe_valid_i & ~stall_base;
  assign ebrk_hit   = ctrl[1] & pipe_ebreak_i & run;
  assign step_hit   = ctrl[0] & (step_arm | (stall_q & ~dbg_stall_i)) & run;
  assign any_hit    = (|bp_match) | ebrk_hit | step_hit;
  assign du_stall_o = stall_base | any_hit;

  always_comb begin
    bp_match = '0;
    for (int n = 0; n < NBP; n++)
      bp_match[n] = bp_en[n] & run & (pipe_pc_i == bp_adr[n]);
  end

  always_comb begin
    rd_dat = '0;
    if (adr == ADR_CTRL) begin
      rd_dat[1:0] = ctrl;
    end else if (adr == ADR_HIT) begin
      rd_dat[0] = hit_step;
      rd_dat[1] = hit_ebrk;
      for (int n = 0; n < NBP; n++) rd_dat[4+n] = hit_bp[n];
    end else if (adr == ADR_NPC) begin
      rd_dat = XLEN'(npc);
    end else begin
      for (int n = 0; n < NBP; n++) begin
        if (adr == ADR_BP + 16'(2*n))   rd_dat = XLEN'(bp_en[n]);
        if (adr == ADR_BP + 16'(2*n+1)) rd_dat = XLEN'(bp_adr[n]);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl     <= '0;
      hit_step <= 1'b0;
      hit_ebrk <= 1'b0;
      hit_bp   <= '0;
      bp_en    <= '0;
      for (int n = 0; n < NBP; n++) bp_adr[n] <= '0;
      npc      <= '0;
      bp_hold  <= 1'b0;
      stall_q  <= 1'b0;
      step_arm <= 1'b0;
      dbg_bp_o <= 1'b0;
    end else begin
      if (wr && adr == ADR_CTRL) ctrl <= dbg_dati_i[1:0];
      // A new hit wins over a simultaneous write-1-to-clear of the same bit.
      hit_step <= step_hit | (hit_step & ~(wr_hit & dbg_dati_i[0]));
      hit_ebrk <= ebrk_hit | (hit_ebrk & ~(wr_hit & dbg_dati_i[1]));
      for (int n = 0; n < NBP; n++) begin
        hit_bp[n] <= bp_match[n] | (hit_bp[n] & ~(wr_hit & dbg_dati_i[4+n]));
        if (wr && adr == ADR_BP + 16'(2*n))   bp_en[n]  <= dbg_dati_i[0];
        if (wr && adr == ADR_BP + 16'(2*n+1)) bp_adr[n] <= PLEN'(dbg_dati_i);
      end
      if ((|bp_match) || ebrk_hit) npc <= pipe_pc_i;
      else if (step_hit)           npc <= pipe_npc_i;
      bp_hold  <= any_hit | (bp_hold & ~dbg_stall_i);
      stall_q  <= dbg_stall_i;
      step_arm <= ctrl[0] & (step_arm | (stall_q & ~dbg_stall_i)) & ~step_hit;
      dbg_bp_o <= any_hit;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      dbg_ack_o    <= 1'b0;
      dbg_dato_o   <= '0;
      du_rf_re_o   <= 1'b0;
      du_rf_we_o   <= 1'b0;
      du_rf_addr_o <= '0;
      du_rf_dat_o  <= '0;
    end else begin
      case (state)
        IDLE: if (dbg_strb_i) begin
          if (is_gpr && dbg_stall_i && !dbg_we_i) begin
            state        <= RFRD;
            du_rf_re_o   <= 1'b1;
            du_rf_addr_o <= adr[4:0];
          end else begin
            state      <= ACK;
            dbg_ack_o  <= 1'b1;
            dbg_dato_o <= dbg_we_i ? '0 : rd_dat;
            if (is_gpr && dbg_we_i && dbg_stall_i && adr[4:0] != 5'd0) begin
              du_rf_we_o   <= 1'b1;
              du_rf_addr_o <= adr[4:0];
              du_rf_dat_o  <= dbg_dati_i;
            end
          end
        end
        RFRD: begin
          state      <= ACK;
          du_rf_re_o <= 1'b0;
          dbg_ack_o  <= 1'b1;
          dbg_dato_o <= rf_dat_i;
        end
        ACK: begin
          state      <= RELEASE;
          dbg_ack_o  <= 1'b0;
          du_rf_we_o <= 1'b0;
          dbg_dato_o <= '0;
        end
        RELEASE: if (!dbg_strb_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_riscv_dbg_unit.sv
// Randomized bench for pu_riscv_dbg_unit against a register-map / hit-rule model.
module tb_pu_riscv_dbg_unit;
  localparam int XLEN = 64;
  localparam int PLEN = 64;
  localparam int NBP  = 2;

  logic            rstn = 1'b0, clk = 1'b0;
  logic            dbg_stall_i = 0, dbg_strb_i = 0, dbg_we_i = 0;
  logic [PLEN-1:0] dbg_addr_i = '0;
  logic [XLEN-1:0] dbg_dati_i = '0, dbg_dato_o;
  logic            dbg_ack_o, dbg_bp_o;
  logic            pipe_valid_i = 0, pipe_ebreak_i = 0;
  logic [PLEN-1:0] pipe_pc_i = '0, pipe_npc_i = '0;
  logic            du_stall_o, du_rf_re_o, du_rf_we_o;
  logic [4:0]      du_rf_addr_o;
  logic [XLEN-1:0] du_rf_dat_o, rf_dat_i;

  logic [63:0] gpr [32];
  logic [1:0]  m_ctrl;
  logic [63:0] m_hit, m_npc;
  logic        m_bpen [NBP];
  logic [63:0] m_bpadr [NBP];
  logic        m_arm, m_hold, m_stl;
  int n_cmp = 0, n_err = 0;

  pu_riscv_dbg_unit #(.XLEN(XLEN), .PLEN(PLEN), .NBP(NBP)) dut (
    .rstn(rstn), .clk(clk), .dbg_stall_i(dbg_stall_i), .dbg_strb_i(dbg_strb_i),
    .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_dati_i(dbg_dati_i),
    .dbg_dato_o(dbg_dato_o), .dbg_ack_o(dbg_ack_o), .dbg_bp_o(dbg_bp_o),
    .pipe_valid_i(pipe_valid_i), .pipe_pc_i(pipe_pc_i), .pipe_npc_i(pipe_npc_i),
    .pipe_ebreak_i(pipe_ebreak_i), .du_stall_o(du_stall_o), .du_rf_re_o(du_rf_re_o),
    .du_rf_we_o(du_rf_we_o), .du_rf_addr_o(du_rf_addr_o), .du_rf_dat_o(du_rf_dat_o),
    .rf_dat_i(rf_dat_i)
  );

  always #5 clk = ~clk;
  assign rf_dat_i = gpr[du_rf_addr_o];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_hit = '0; m_npc = '0; m_arm = 0; m_hold = 0;
    for (int n = 0; n < NBP; n++) begin m_bpen[n] = 0; m_bpadr[n] = '0; end
  endtask

  task automatic drive_stall(input logic v);
    if (m_stl && !v && m_ctrl[0]) m_arm = 1;
    if (v) m_hold = 0;
    m_stl = v;
    dbg_stall_i = v;
  endtask

  task automatic set_stall(input logic v);
    @(negedge clk);
    drive_stall(v);
  endtask

  function automatic logic [63:0] m_read(input logic [15:0] a, input logic st);
    logic [63:0] r;
    r = '0;
    if (a == 16'h0000) r = {62'b0, m_ctrl};
    else if (a == 16'h0001) r = m_hit;
    else if (a == 16'h0100) r = m_npc;
    else if (a[15:5] == 11'h080) r = st ? gpr[a[4:0]] : 64'h0;
    else for (int n = 0; n < NBP; n++) begin
      if (a == 16'(16 + 2*n)) r = {63'b0, m_bpen[n]};
      if (a == 16'(17 + 2*n)) r = m_bpadr[n];
    end
    return r;
  endfunction

  task automatic m_write(input logic [15:0] a, input logic [63:0] d, input logic st);
    if (a == 16'h0000) begin m_ctrl = d[1:0]; if (!d[0]) m_arm = 0; end
    else if (a == 16'h0001) m_hit = m_hit & ~d;
    else if (a[15:5] == 11'h080) begin if (st && a[4:0] != 5'd0) gpr[a[4:0]] = d; end
    else for (int n = 0; n < NBP; n++) begin
      if (a == 16'(16 + 2*n)) m_bpen[n] = d[0];
      if (a == 16'(17 + 2*n)) m_bpadr[n] = d;
    end
  endtask

  task automatic bus(input string tag, input logic w, input logic [15:0] a,
                     input logic [63:0] d, input logic st, input int hold);
    int lat, re_n, we_n, acks, exp_lat, exp_we;
    logic [4:0] wa; logic [63:0] wd, rd, exp_rd; logic gp;
    lat = 0; re_n = 0; we_n = 0; acks = 0; wa = '0; wd = '0; rd = '0;
    gp = (a[15:5] == 11'h080);
    exp_lat = (gp && st && !w) ? 2 : 1;
    exp_we  = (gp && w && st && a[4:0] != 5'd0) ? 1 : 0;
    exp_rd  = m_read(a, st);
    @(negedge clk);
    drive_stall(st);
    dbg_strb_i = 1; dbg_we_i = w; dbg_dati_i = d;
    dbg_addr_i = {$urandom, 16'($urandom), a};
    while (acks == 0 && lat < 8) begin
      @(negedge clk); lat++;
      if (du_rf_re_o) re_n++;
      if (du_rf_we_o) begin we_n++; wa = du_rf_addr_o; wd = du_rf_dat_o; end
      if (dbg_ack_o) begin acks = 1; rd = dbg_dato_o; end
    end
    if (acks == 0) chk({tag, "_ack_timeout"}, 64'(acks), 64'(1));
    else chk({tag, "_ack_latency"}, 64'(lat), 64'(exp_lat));
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      if (dbg_ack_o) acks++;
      if (du_rf_we_o) we_n++;
    end
    chk({tag, "_ack_once"}, 64'(acks), 64'(1));
    dbg_strb_i = 0; dbg_we_i = 0;
    if (gp && w) begin
      chk({tag, "_rf_we"}, 64'(we_n), 64'(exp_we));
      if (exp_we == 1) begin
        chk({tag, "_rf_waddr"}, 64'(wa), 64'(a[4:0]));
        chk({tag, "_rf_wdat"}, wd, d);
      end
    end
    if (gp && !w) chk({tag, "_rf_re"}, 64'(re_n), 64'(st ? 1 : 0));
    if (w) m_write(a, d, st);
    else chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  task automatic retire(input logic [63:0] pc, input logic [63:0] npc, input logic eb);
    logic [NBP-1:0] bpm; logic run, e, s, hit;
    run = !m_stl && !m_hold;
    bpm = '0;
    for (int n = 0; n < NBP; n++) bpm[n] = run && m_bpen[n] && (m_bpadr[n] == pc);
    e = run && m_ctrl[1] && eb;
    s = run && m_ctrl[0] && m_arm;
    hit = (|bpm) || e || s;
    @(negedge clk);
    pipe_valid_i = 1; pipe_pc_i = pc; pipe_npc_i = npc; pipe_ebreak_i = eb;
    #1;
    chk("stall_at_hit", 64'(du_stall_o), 64'(m_stl | m_hold | hit));
    @(negedge clk);
    chk("bp_pulse", 64'(dbg_bp_o), 64'(hit));
    pipe_valid_i = 0; pipe_ebreak_i = 0;
    for (int n = 0; n < NBP; n++) if (bpm[n]) m_hit[4+n] = 1;
    if (e) m_hit[1] = 1;
    if (s) begin m_hit[0] = 1; m_arm = 0; end
    if ((|bpm) || e) m_npc = pc;
    else if (s) m_npc = npc;
    if (hit) m_hold = 1;
    @(negedge clk);
    chk("bp_single_pulse", 64'(dbg_bp_o), 64'(0));
    chk("stall_hold", 64'(du_stall_o), 64'(m_stl | m_hold));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] a; logic [63:0] pc;
    int n;
    model_reset();
    m_stl = 0;
    for (int i = 0; i < 32; i++) gpr[i] = {$urandom, $urandom};
    gpr[0] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(dbg_ack_o), 64'(0));
    chk("rst_bp", 64'(dbg_bp_o), 64'(0));
    chk("rst_stall", 64'(du_stall_o), 64'(0));
    chk("rst_re", 64'(du_rf_re_o), 64'(0));
    chk("rst_we", 64'(du_rf_we_o), 64'(0));
    chk("rst_dato", dbg_dato_o, 64'(0));
    chk("rst_rfdat", du_rf_dat_o, 64'(0));
    rstn = 1;

    bus("wr_ctrl", 1, 16'h0000, 64'h3, 0, 0);
    bus("rd_ctrl", 0, 16'h0000, 64'h0, 0, 0);
    bus("wr_x5", 1, 16'h1005, 64'hDEAD_BEEF, 1, 0);
    bus("rd_x5", 0, 16'h1005, 64'h0, 1, 0);
    bus("wr_x0", 1, 16'h1000, 64'h1234, 1, 0);
    bus("rd_x0", 0, 16'h1000, 64'h0, 1, 0);
    bus("rd_unmapped", 0, 16'h0777, 64'h0, 0, 0);
    bus("rd_gpr_unstalled", 0, 16'h1007, 64'h0, 0, 0);
    bus("wr_gpr_unstalled", 1, 16'h1006, 64'h55, 0, 0);
    bus("strb_held", 0, 16'h0000, 64'h0, 0, 5);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: a = 16'h0000;
        1: a = 16'h0001;
        2: a = 16'h0010 | 16'($urandom_range(0, 3));
        3: a = 16'h0100;
        4, 5: a = 16'h1000 | 16'($urandom_range(0, 31));
        6: a = 16'($urandom);
        default: a = 16'h0777;
      endcase
      bus("rnd", 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
          1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    bus("bp_cfg_ctrl", 1, 16'h0000, 64'h0, 1, 0);
    bus("bp_cfg_en1", 1, 16'h0012, 64'h0, 1, 0);
    bus("bp_cfg_adr0", 1, 16'h0011, 64'h200, 1, 0);
    bus("bp_cfg_en0", 1, 16'h0010, 64'h1, 1, 0);
    bus("bp_clr_hit", 1, 16'h0001, '1, 1, 0);
    set_stall(0);
    retire(64'h200, 64'h204, 0);
    set_stall(1);
    bus("bp0_hit", 0, 16'h0001, 64'h0, 1, 0);
    bus("bp0_npc", 0, 16'h0100, 64'h0, 1, 0);
    bus("bp0_w1c", 1, 16'h0001, 64'h10, 1, 0);
    bus("bp0_hit_clr", 0, 16'h0001, 64'h0, 1, 0);

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, NBP - 1);
      pc = {$urandom, $urandom_range(0, 255), 2'b00};
      bus("rbp_adr", 1, 16'(17 + 2*n), pc, 1, 0);
      bus("rbp_en", 1, 16'(16 + 2*n), 64'($urandom_range(0, 1)), 1, 0);
      set_stall(0);
      retire($urandom_range(0, 1) ? pc : {$urandom, $urandom}, pc + 4, 0);
      set_stall(1);
      bus("rbp_hit", 0, 16'h0001, 64'h0, 1, 0);
      bus("rbp_npc", 0, 16'h0100, 64'h0, 1, 0);
      bus("rbp_clr", 1, 16'h0001, '1, 1, 0);
    end

    bus("ss_dis0", 1, 16'h0010, 64'h0, 1, 0);
    bus("ss_dis1", 1, 16'h0012, 64'h0, 1, 0);
    bus("ss_ctrl", 1, 16'h0000, 64'h1, 1, 0);
    set_stall(0);
    retire(64'h100, 64'h104, 0);
    retire(64'h104, 64'h108, 0);
    set_stall(1);
    bus("ss_hit", 0, 16'h0001, 64'h0, 1, 0);
    bus("ss_npc", 0, 16'h0100, 64'h0, 1, 0);
    bus("ss_w1c", 1, 16'h0001, 64'h1, 1, 0);
    bus("ss_hit_clr", 0, 16'h0001, 64'h0, 1, 0);

    bus("eb_ctrl", 1, 16'h0000, 64'h2, 1, 0);
    bus("eb_adr0", 1, 16'h0011, 64'h400, 1, 0);
    bus("eb_en0", 1, 16'h0010, 64'h1, 1, 0);
    set_stall(0);
    retire(64'h400, 64'h404, 1);
    set_stall(1);
    bus("eb_bp_hit", 0, 16'h0001, 64'h0, 1, 0);
    bus("eb_bp_npc", 0, 16'h0100, 64'h0, 1, 0);

    @(negedge clk);
    drive_stall(1);
    dbg_strb_i = 1; dbg_we_i = 0; dbg_addr_i = 64'h1005;
    @(negedge clk);
    chk("rfrd_re", 64'(du_rf_re_o), 64'(1));
    rstn = 0;
    #1;
    chk("rstmid_ack", 64'(dbg_ack_o), 64'(0));
    chk("rstmid_re", 64'(du_rf_re_o), 64'(0));
    chk("rstmid_we", 64'(du_rf_we_o), 64'(0));
    chk("rstmid_dato", dbg_dato_o, 64'(0));
    chk("rstmid_bp", 64'(dbg_bp_o), 64'(0));
    dbg_strb_i = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_ack", 64'(dbg_ack_o), 64'(0));
    end
    rstn = 1;
    model_reset();
    bus("post_rd_ctrl", 0, 16'h0000, 64'h0, 1, 0);
    bus("post_rd_hit", 0, 16'h0001, 64'h0, 1, 0);
    bus("post_rd_bpadr", 0, 16'h0011, 64'h0, 1, 0);
    bus("post_wr_ctrl", 1, 16'h0000, 64'h3, 1, 0);
    bus("post_rd_ctrl2", 0, 16'h0000, 64'h0, 1, 0);
    bus("post_rd_x5", 0, 16'h1005, 64'h0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
